// File: rtl/led_scan_pkg.sv
// Shared types and constants for the multiplexed 8-digit LED scan controller.
package led_scan_pkg;

    typedef enum logic {
        SCAN  = 1'b0,
        GUARD = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam int         NUM_DIG = 8;

    // Active-low one-hot anode select for a digit index.
    function automatic logic [7:0] an_decode(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter that parks at zero; tc_o flags the terminal count.
module scan_timer #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// Eight-digit LED scan controller with double-buffered, tear-free frame update.
//   state | meaning
//   SCAN  | anode idx driven with active[idx] for DWELL cycles
//   GUARD | all anodes off for GUARD cycles before advancing idx
module led_scan_ctrl #(
    parameter int DWELL = 100_000,
    parameter int GUARD = 1_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [7:0] in4,
    input  logic [7:0] in5,
    input  logic [7:0] in6,
    input  logic [7:0] in7,
    input  logic       load,
    input  logic       blank,
    output logic [7:0] an,
    output logic [7:0] sseg,
    output logic       frame_done,
    output logic       pending
);
    import led_scan_pkg::*;

    localparam int               CNT_MAX  = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int               CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD - 1);

    scan_state_t state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        started_q;
    logic        tmr_tc;
    logic        tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic        boundary;

    logic [NUM_DIG-1:0][7:0] in_bus;
    logic [NUM_DIG-1:0][7:0] shadow_q, shadow_d;
    logic [NUM_DIG-1:0][7:0] active_q, active_d;
    logic        pending_q, pending_d;
    logic [7:0]  an_q, an_d;
    logic [7:0]  sseg_q, sseg_d;
    logic        frame_done_q;

    assign in_bus = {in7, in6, in5, in4, in3, in2, in1, in0};

    // The first edge after reset only puts digit 0 on the anodes; counting
    // starts from there so digit 0 gets its full dwell.
    scan_timer #(
        .W       (CNT_W),
        .RST_VAL (DWELL_LD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (started_q),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    assign tmr_load = started_q && tmr_tc;
    assign tmr_val  = (state_q == led_scan_pkg::SCAN) ? GUARD_LD : DWELL_LD;
    assign boundary = tmr_load && (state_q == led_scan_pkg::GUARD) && (idx_q == 3'd7);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (tmr_load) begin
            if (state_q == led_scan_pkg::SCAN) begin
                state_d = led_scan_pkg::GUARD;
            end else begin
                state_d = led_scan_pkg::SCAN;
                idx_d   = idx_q + 3'd1;
            end
        end
    end

    // Boundary copy uses the old shadow, so a same-cycle load stays pending.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = in_bus;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        an_d   = AN_OFF;
        sseg_d = SEG_OFF;
        if (!blank && (state_d == led_scan_pkg::SCAN)) begin
            an_d   = an_decode(idx_d);
            sseg_d = active_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= led_scan_pkg::SCAN;
            idx_q        <= 3'd0;
            started_q    <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= AN_OFF;
            sseg_q       <= SEG_OFF;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            started_q    <= 1'b1;
            frame_done_q <= boundary;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= {NUM_DIG{SEG_OFF}};
            active_q  <= {NUM_DIG{SEG_OFF}};
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule
